// File: rtl/uart_host_pkg.sv
// uart_host_pkg -- shared definitions for the uart host and the attached uart.
//   state_t       : host FSM state encoding (IDLE, WRITE, READ)
//   RDY/ERR/PRT_* : position of the status flags in the uart readdata word,
//                   given as an offset down from the MSB (bit = ADW - offset)
//   rd_bit()      : converts an offset into an absolute bit index for a width
package uart_host_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  localparam int RDY_OFS = 1;  // receive data ready
  localparam int ERR_OFS = 2;  // receive overrun
  localparam int PRT_OFS = 3;  // parity error of the received character

  function automatic int rd_bit(input int adw, input int ofs);
    return adw - ofs;
  endfunction

endpackage

// File: rtl/uart_host_rr_arb.sv
// rr_arb -- round-robin arbiter over N_REQ requesters.
//   clk, rst : clock, asynchronous active-high reset
//   req      : request vector
//   adv      : the current grant is taken; move the pointer onto it
//   gnt      : one-hot grant (combinational), zero when no request
//   gnt_vld  : at least one request is pending
// The search starts just after the last taken grant. The pointer resets to
// N_REQ-1 so requester 0 is the first one looked at.
module rr_arb #(
  parameter int N_REQ = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             adv,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_vld
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] cand;

  // Walk from the farthest candidate to the nearest one; the last hit wins,
  // which leaves the nearest requester after the pointer in gnt_idx.
  always_comb begin
    gnt_idx = ptr_reg;
    cand    = ptr_reg;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = PW'((int'(ptr_reg) + k) % N_REQ);
      if (req[cand]) begin
        gnt_idx = cand;
      end
    end
    gnt_vld = |req;
    gnt     = gnt_vld ? (N_REQ'(1) << gnt_idx) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= PW'(N_REQ - 1);
    end else if (adv && gnt_vld) begin
      ptr_reg <= gnt_idx;
    end
  end

endmodule

// File: rtl/uart_host.sv
// uart_host -- Avalon master that feeds N_REQ byte requesters into a uart and
// drains its receive side into a valid/ready stream.
//   clk, rst                    : clock, asynchronous active-high reset
//   req_valid/req_data/req_ready: transmit requesters (ready = 1-cycle accept)
//   rx_valid/rx_data/rx_prt     : received byte with its parity error flag
//   rx_ready                    : consumer accepts the received byte
//   ovf_cnt                     : saturating count of uart overruns seen
//   uart_*                      : Avalon master toward the uart slave
// Reads take priority over writes but are held off while a received byte is
// still waiting for the consumer; the uart then reports the overrun itself.
module uart_host
  import uart_host_pkg::*;
#(
  parameter int    N_REQ    = 4,
  parameter int    BYTESIZE = 8,
  parameter string PARITY   = "NONE",
  parameter int    ADW      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*BYTESIZE-1:0] req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      rx_valid,
  output logic [BYTESIZE-1:0]       rx_data,
  output logic                      rx_prt,
  input  logic                      rx_ready,
  output logic [7:0]                ovf_cnt,
  output logic                      uart_read,
  output logic                      uart_write,
  output logic [ADW-1:0]            uart_writedata,
  input  logic [ADW-1:0]            uart_readdata,
  input  logic                      uart_waitrequest,
  input  logic                      uart_interrupt
);

  localparam bit HAS_PRT = (PARITY != "NONE");
  localparam int RDY_BIT = rd_bit(ADW, RDY_OFS);
  localparam int ERR_BIT = rd_bit(ADW, ERR_OFS);
  localparam int PRT_BIT = rd_bit(ADW, PRT_OFS);

  state_t                state_reg, state_next;
  logic                  adv;
  logic [N_REQ-1:0]      gnt;
  logic                  gnt_vld;
  logic [BYTESIZE-1:0]   gnt_byte;
  logic [ADW-1:0]        writedata_reg;
  logic                  rx_valid_reg;
  logic [BYTESIZE-1:0]   rx_data_reg;
  logic                  rx_prt_reg;
  logic [7:0]            ovf_cnt_reg;
  logic                  rd_rdy;
  logic                  rd_err;
  logic                  unused_readdata;

  rr_arb #(.N_REQ(N_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .adv     (adv),
    .gnt     (gnt),
    .gnt_vld (gnt_vld)
  );

  // Byte of the granted requester (gnt is one-hot, so OR-ing is a mux).
  always_comb begin
    gnt_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        gnt_byte = gnt_byte | req_data[i*BYTESIZE +: BYTESIZE];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    adv        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (uart_interrupt && !rx_valid_reg) begin
          state_next = READ;
        end else if (gnt_vld && !rst) begin
          // The accept pulse is tied to this decision; rst keeps it quiet
          // while the state register is being held.
          state_next = WRITE;
          adv        = 1'b1;
        end
      end
      WRITE: begin
        if (!uart_waitrequest) begin
          state_next = IDLE;
        end
      end
      READ:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign req_ready  = adv ? gnt : '0;
  assign uart_write = (state_reg == WRITE);
  assign uart_read  = (state_reg == READ);

  // uart reads never stall, so readdata is valid in the single READ cycle.
  assign rd_rdy = uart_read & uart_readdata[RDY_BIT];
  assign rd_err = uart_read & uart_readdata[ERR_BIT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      writedata_reg <= '0;
      rx_valid_reg  <= 1'b0;
      rx_data_reg   <= '0;
      rx_prt_reg    <= 1'b0;
      ovf_cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      if (adv) begin
        writedata_reg <= ADW'(gnt_byte);
      end
      if (rd_rdy) begin
        rx_valid_reg <= 1'b1;
        rx_data_reg  <= uart_readdata[BYTESIZE-1:0];
        rx_prt_reg   <= HAS_PRT ? uart_readdata[PRT_BIT] : 1'b0;
      end else if (rx_valid_reg && rx_ready) begin
        rx_valid_reg <= 1'b0;
      end
      if (rd_err && (ovf_cnt_reg != 8'hFF)) begin
        ovf_cnt_reg <= ovf_cnt_reg + 8'd1;
      end
    end
  end

  assign uart_writedata = writedata_reg;
  assign rx_valid       = rx_valid_reg;
  assign rx_data        = rx_data_reg;
  assign rx_prt         = rx_prt_reg;
  assign ovf_cnt        = ovf_cnt_reg;

  // Only a few readdata bits carry meaning; fold the rest into a sink.
  assign unused_readdata = ^uart_readdata;

endmodule
